burst_ram: RTL and testbench

- Cycle-accurate model of the Gowin PSRAM HS IP user interface.
- Sits directly downstream of the cache and consumes its br_* command/data port.
- Serves 4-beat 64-bit read and write bursts with fixed read latency, enforces the minimum command interval, and flags protocol violations.
- Used as the memory behind the cache in simulation and in small-depth FPGA builds.

---
 rtl/burst_ram_pkg.sv | 16 +
 rtl/burst_ram_delay_line.sv | 31 +++
 rtl/burst_ram.sv | 195 +++++++++++++++++++
 tb/tb_burst_ram.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ram_pkg.sv
// Shared constants and FSM state type for the burst_ram PSRAM user-interface model.
package burst_ram_pkg;

   localparam int BURST_LENGTH = 4;
   localparam int BEAT_W       = 2;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_IDLE    = 2'd1,
      ST_WR_BEAT = 2'd2
   } state_t;

endpackage

// File: rtl/burst_ram_delay_line.sv
// Fixed-depth shift register with synchronous clear; DEPTH=0 degenerates to a wire.
module burst_ram_delay_line #(
   parameter int DEPTH = 5,
   parameter int WIDTH = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign dout_o = din_i;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_q [DEPTH];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else begin
               stage_q[0] <= din_i;
               for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign dout_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/burst_ram.sv
// Cycle-accurate model of the PSRAM HS user interface: 4-beat 64-bit bursts,
// fixed read latency, minimum command interval and sticky reject flag.
//
//   state      | meaning
//   ST_INIT    | calibration countdown after reset, all commands rejected
//   ST_IDLE    | ready; a write accept stores beat 0 and moves to ST_WR_BEAT
//   ST_WR_BEAT | storing write beats 1..3
module burst_ram
   import burst_ram_pkg::*;
#(
   parameter int BURST_RAM_DEPTH_BITWIDTH = 21,
   parameter int READ_LATENCY             = 6,
   parameter int COMMAND_DELAY_INTERVAL   = 14,
   parameter int CYCLES_BEFORE_INITIATED  = 10
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                cmd,
   input  logic                                cmd_en,
   input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] addr,
   input  logic [63:0]                         wr_data,
   input  logic [7:0]                          data_mask,
   output logic [63:0]                         rd_data,
   output logic                                rd_data_valid,
   output logic                                init_calib,
   output logic                                busy,
   output logic                                cmd_error
);

   localparam int AW     = BURST_RAM_DEPTH_BITWIDTH;
   localparam int INTV_W = $clog2(COMMAND_DELAY_INTERVAL + 1);
   localparam int INIT_W = $clog2(CYCLES_BEFORE_INITIATED + 1);

   generate
      if (READ_LATENCY < 1 || READ_LATENCY > 10 ||
          READ_LATENCY + BURST_LENGTH > COMMAND_DELAY_INTERVAL ||
          CYCLES_BEFORE_INITIATED < 1) begin : g_bad_params
         $fatal(1, "burst_ram: illegal READ_LATENCY / COMMAND_DELAY_INTERVAL / CYCLES_BEFORE_INITIATED");
      end
   endgenerate

   state_t              state_q, state_d;
   logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
   logic [INTV_W-1:0]   intv_q, intv_d;
   logic [BEAT_W-1:0]   wr_beat_q, wr_beat_d;
   logic [AW-1:0]       wr_addr_q, wr_addr_d;
   logic                cmd_error_q, cmd_error_d;

   logic                init_calib_w;
   logic                accept;
   logic                we;
   logic [AW-1:0]       waddr;

   logic [63:0]         mem_q [2**AW];

   // Byte enables are accepted for interface compatibility; every write is full-width.
   logic                unused_mask;
   assign unused_mask = ^data_mask;

   assign init_calib_w = (state_q != ST_INIT);

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      intv_d      = intv_q;
      wr_beat_d   = wr_beat_q;
      wr_addr_d   = wr_addr_q;
      cmd_error_d = cmd_error_q;
      accept      = 1'b0;
      we          = 1'b0;
      waddr       = addr;

      if (cmd_en) begin
         if (init_calib_w && intv_q == '0) accept = 1'b1;
         else                              cmd_error_d = 1'b1;
      end

      if (accept)             intv_d = INTV_W'(COMMAND_DELAY_INTERVAL - 1);
      else if (intv_q != '0)  intv_d = intv_q - 1'b1;

      case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q - 1'b1;
            if (init_cnt_q == INIT_W'(1)) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (accept && cmd == CMD_WRITE) begin
               we        = 1'b1;
               wr_addr_d = addr;
               wr_beat_d = BEAT_W'(1);
               state_d   = ST_WR_BEAT;
            end
         end
         ST_WR_BEAT: begin
            we        = 1'b1;
            waddr     = wr_addr_q + AW'(wr_beat_q);
            wr_beat_d = wr_beat_q + 1'b1;
            if (wr_beat_q == BEAT_W'(BURST_LENGTH - 1)) state_d = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= INIT_W'(CYCLES_BEFORE_INITIATED);
         intv_q      <= '0;
         wr_beat_q   <= '0;
         wr_addr_q   <= '0;
         cmd_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         intv_q      <= intv_d;
         wr_beat_q   <= wr_beat_d;
         wr_addr_q   <= wr_addr_d;
         cmd_error_q <= cmd_error_d;
      end
   end

   // Storage is never cleared; reset only suppresses a write in flight.
   always_ff @(posedge clk) begin
      if (we && !rst) mem_q[waddr] <= wr_data;
   end

   // The output data register adds one cycle, so the delay line is one stage short.
   logic          rd_launch;
   logic          rd_pipe_valid;
   logic [AW-1:0] rd_pipe_addr;

   assign rd_launch = accept && (cmd == CMD_READ);

   burst_ram_delay_line #(
      .DEPTH (READ_LATENCY - 1),
      .WIDTH (AW + 1)
   ) u_rd_delay (
      .clk    (clk),
      .rst    (rst),
      .din_i  ({rd_launch, addr}),
      .dout_o ({rd_pipe_valid, rd_pipe_addr})
   );

   logic              rd_active_q, rd_active_d;
   logic [BEAT_W-1:0] rd_beat_q, rd_beat_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic              rd_valid_q;
   logic [63:0]       rd_data_q;
   logic              rd_fetch;
   logic [AW-1:0]     rd_raddr;

   always_comb begin
      rd_active_d = rd_active_q;
      rd_beat_d   = rd_beat_q;
      rd_addr_d   = rd_addr_q;
      rd_raddr    = rd_addr_q;
      rd_fetch    = 1'b0;

      if (rd_pipe_valid) begin
         rd_fetch    = 1'b1;
         rd_raddr    = rd_pipe_addr;
         rd_addr_d   = rd_pipe_addr + 1'b1;
         rd_beat_d   = BEAT_W'(1);
         rd_active_d = 1'b1;
      end else if (rd_active_q) begin
         rd_fetch  = 1'b1;
         rd_addr_d = rd_addr_q + 1'b1;
         rd_beat_d = rd_beat_q + 1'b1;
         if (rd_beat_q == BEAT_W'(BURST_LENGTH - 1)) rd_active_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_active_q <= 1'b0;
         rd_beat_q   <= '0;
         rd_addr_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         rd_active_q <= rd_active_d;
         rd_beat_q   <= rd_beat_d;
         rd_addr_q   <= rd_addr_d;
         rd_valid_q  <= rd_fetch;
         if (rd_fetch) rd_data_q <= mem_q[rd_raddr];
      end
   end

   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_valid_q;
   assign init_calib    = init_calib_w;
   assign busy          = !init_calib_w || (intv_q != '0);
   assign cmd_error     = cmd_error_q;

endmodule

// File: tb/tb_burst_ram.sv
// Self-checking bench for burst_ram: directed scenarios plus randomized bursts
// checked against an associative-array memory model and a cycle-stamp interval model.
module tb_burst_ram;

   localparam int AW  = 21;
   localparam int L   = 6;
   localparam int CDI = 14;
   localparam int CBI = 10;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clk;
   logic          rst;
   logic          cmd;
   logic          cmd_en;
   logic [AW-1:0] addr;
   logic [63:0]   wr_data;
   logic [7:0]    data_mask;
   logic [63:0]   rd_data;
   logic          rd_data_valid;
   logic          init_calib;
   logic          busy;
   logic          cmd_error;

   burst_ram #(
      .BURST_RAM_DEPTH_BITWIDTH (AW),
      .READ_LATENCY             (L),
      .COMMAND_DELAY_INTERVAL   (CDI),
      .CYCLES_BEFORE_INITIATED  (CBI)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd           (cmd),
      .cmd_en        (cmd_en),
      .addr          (addr),
      .wr_data       (wr_data),
      .data_mask     (data_mask),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .init_calib    (init_calib),
      .busy          (busy),
      .cmd_error     (cmd_error)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int t_last   = 0;

   logic [63:0]  mem_model [int unsigned];
   int unsigned  written_q [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1, "watchdog");
   end

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic check_issue_ready(input string tag);
      logic exp_busy;
      exp_busy = (cyc - t_last) < CDI;
      n_checks++;
      if (busy !== exp_busy) begin
         n_errors++;
         $display("FAIL %s_busy at cycle %0d: got %b expected %b", tag, cyc, busy, exp_busy);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3);
      logic [63:0] d [4];
      d = '{d0, d1, d2, d3};
      check_issue_ready("wr");
      t_last    = cyc;
      cmd_en    = 1'b1;
      cmd       = 1'b1;
      addr      = a;
      wr_data   = d[0];
      data_mask = 8'($urandom);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         cmd_en  = 1'b0;
         cmd     = 1'($urandom);
         addr    = AW'($urandom);
         wr_data = d[k];
      end
      @(negedge clk);
      wr_data = {$urandom, $urandom};
      for (int k = 0; k < 4; k++) begin
         int unsigned idx;
         idx = (int'(a) + k) % DEPTH;
         if (!mem_model.exists(idx)) written_q.push_back(idx);
         mem_model[idx] = d[k];
      end
   endtask

   task automatic do_read(input logic [AW-1:0] a, input string tag);
      logic [63:0] exp [4];
      bit          known [4];
      logic        exp_v;
      for (int k = 0; k < 4; k++) begin
         int unsigned idx;
         idx      = (int'(a) + k) % DEPTH;
         known[k] = mem_model.exists(idx);
         exp[k]   = known[k] ? mem_model[idx] : 64'h0;
      end
      check_issue_ready(tag);
      t_last = cyc;
      cmd_en = 1'b1;
      cmd    = 1'b0;
      addr   = a;
      for (int c = 1; c <= L + 4; c++) begin
         @(negedge clk);
         cmd_en = 1'b0;
         addr   = AW'($urandom);
         exp_v  = (c >= L) && (c <= L + 3);
         n_checks++;
         if (rd_data_valid !== exp_v) begin
            n_errors++;
            $display("FAIL %s_valid addr=%h T+%0d: got %b expected %b", tag, a, c, rd_data_valid, exp_v);
         end
         if (exp_v && known[c-L]) begin
            n_checks++;
            if (rd_data !== exp[c-L]) begin
               n_errors++;
               $display("FAIL %s_data addr=%h beat %0d: got %h expected %h", tag, a, c - L, rd_data, exp[c-L]);
            end
         end
         if (c == L + 4 && known[3]) begin
            n_checks++;
            if (rd_data !== exp[3]) begin
               n_errors++;
               $display("FAIL %s_hold addr=%h: got %h expected %h", tag, a, rd_data, exp[3]);
            end
         end
      end
   endtask

   // Call at a negedge with rst high; releases reset and checks the calibration window.
   task automatic check_init();
      rst = 1'b0;
      for (int i = 0; i < CBI; i++) begin
         n_checks++;
         if (init_calib !== 1'b0 || busy !== 1'b1 || rd_data_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL init_wait cycle %0d: init=%b busy=%b valid=%b expected 0 1 0", i, init_calib, busy, rd_data_valid);
         end
         @(negedge clk);
      end
      n_checks++;
      if (init_calib !== 1'b1 || busy !== 1'b0 || cmd_error !== 1'b0 || rd_data_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL init_done: init=%b busy=%b err=%b valid=%b expected 1 0 0 0", init_calib, busy, cmd_error, rd_data_valid);
      end
      t_last = cyc - CDI;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_en = 1'b0; cmd = 1'b0; addr = '0; wr_data = '0; data_mask = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (rd_data !== 64'h0 || rd_data_valid !== 1'b0 || init_calib !== 1'b0 || busy !== 1'b1 || cmd_error !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_values: data=%h valid=%b init=%b busy=%b err=%b expected 0 0 0 1 0",
                  rd_data, rd_data_valid, init_calib, busy, cmd_error);
      end
      check_init();
   endtask

   task automatic test_write_read();
      do_write(21'h10, 64'h1111, 64'h2222, 64'h3333, 64'h4444);
      wait_to(t_last + CDI);
      do_read(21'h10, "wr_rd");
   endtask

   task automatic test_wrap();
      wait_to(t_last + CDI);
      do_write(21'h1FFFFE, 64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
               64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D);
      wait_to(t_last + CDI);
      do_read(21'h1FFFFE, "wrap");
   endtask

   task automatic test_cache_traffic();
      wait_to(t_last + CDI);
      do_write(21'h200, 64'hC0DE_0000, 64'hC0DE_0001, 64'hC0DE_0002, 64'hC0DE_0003);
      wait_to(t_last + CDI);
      do_read(21'h200, "miss_fill");
      wait_to(t_last + CDI);
      do_write(21'h200, 64'hD1A7_0000, 64'hD1A7_0001, 64'hD1A7_0002, 64'hD1A7_0003);
      wait_to(t_last + CDI);
      do_read(21'h200, "evict_rb");
      n_checks++;
      if (cmd_error !== 1'b0) begin
         n_errors++;
         $display("FAIL cache_cmd_error: got %b expected 0", cmd_error);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 16; n++) begin
         wait_to(t_last + CDI + int'($urandom_range(0, 3)));
         if (written_q.size() == 0 || $urandom_range(0, 1) == 0) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'(21'h1FFFFC + $urandom_range(0, 3)) : AW'($urandom);
            do_write(a, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
         end else begin
            do_read(AW'(written_q[$urandom_range(0, written_q.size() - 1)]), "rnd");
         end
      end
      n_checks++;
      if (cmd_error !== 1'b0) begin
         n_errors++;
         $display("FAIL rnd_cmd_error: got %b expected 0", cmd_error);
      end
   endtask

   task automatic test_reject();
      wait_to(t_last + CDI - 1);
      n_checks++;
      if (busy !== 1'b1) begin
         n_errors++;
         $display("FAIL rej_busy: got %b expected 1", busy);
      end
      cmd_en  = 1'b1;
      cmd     = 1'b1;
      addr    = 21'h10;
      wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      cmd_en = 1'b0;
      n_checks++;
      if (cmd_error !== 1'b1) begin
         n_errors++;
         $display("FAIL rej_cmd_error: got %b expected 1", cmd_error);
      end
      do_read(21'h10, "rej_rd");
      wait_to(t_last + CDI);
      do_read(21'h10, "rej_rd2");
      n_checks++;
      if (cmd_error !== 1'b1) begin
         n_errors++;
         $display("FAIL rej_sticky: got %b expected 1", cmd_error);
      end
   endtask

   task automatic test_mid_read_reset();
      logic [63:0] exp0;
      logic        exp_v;
      wait_to(t_last + CDI);
      exp0 = mem_model[32'h10];
      check_issue_ready("mr");
      t_last = cyc;
      cmd_en = 1'b1;
      cmd    = 1'b0;
      addr   = 21'h10;
      for (int c = 1; c <= L + 1; c++) begin
         @(negedge clk);
         cmd_en = 1'b0;
         exp_v  = (c >= L);
         n_checks++;
         if (rd_data_valid !== exp_v) begin
            n_errors++;
            $display("FAIL mr_valid T+%0d: got %b expected %b", c, rd_data_valid, exp_v);
         end
         if (c == L) begin
            n_checks++;
            if (rd_data !== exp0) begin
               n_errors++;
               $display("FAIL mr_data0: got %h expected %h", rd_data, exp0);
            end
         end
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rd_data_valid !== 1'b0 || init_calib !== 1'b0 || busy !== 1'b1 || rd_data !== 64'h0) begin
         n_errors++;
         $display("FAIL mr_after_rst: valid=%b init=%b busy=%b data=%h expected 0 0 1 0",
                  rd_data_valid, init_calib, busy, rd_data);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (rd_data_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mr_no_beats: got %b expected 0", rd_data_valid);
         end
      end
      check_init();
      do_read(21'h10, "post_rst");
   endtask

   initial begin
      rst = 1'b1; cmd_en = 1'b0; cmd = 1'b0; addr = '0; wr_data = '0; data_mask = '0;
      test_reset();
      test_write_read();
      test_wrap();
      test_cache_traffic();
      test_random();
      test_reject();
      test_mid_read_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
